// File: rtl/mem_shared_rd_if.sv
// Bus bundle for mem_shared_rd: one full-width write port and three
// narrow read requesters with ready/valid handshakes.
interface mem_shared_rd_if #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 16
);
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [DATA_W-1:0]  wr_data;

  logic               rd_req1;
  logic               rd_req2;
  logic               rd_req3;
  logic [ADDR_W-1:0]  rd_addr1;
  logic [ADDR_W-1:0]  rd_addr2;
  logic [ADDR_W-1:0]  rd_addr3;

  logic               rd_ready1;
  logic               rd_ready2;
  logic               rd_ready3;
  logic               rd_valid1;
  logic               rd_valid2;
  logic               rd_valid3;
  logic [SLICE_W-1:0] rd_data1;
  logic [SLICE_W-1:0] rd_data2;
  logic [SLICE_W-1:0] rd_data3;

  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_req1, rd_req2, rd_req3, rd_addr1, rd_addr2, rd_addr3,
    input  rd_ready1, rd_ready2, rd_ready3,
    input  rd_valid1, rd_valid2, rd_valid3,
    input  rd_data1, rd_data2, rd_data3
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_req1, rd_req2, rd_req3, rd_addr1, rd_addr2, rd_addr3,
    output rd_ready1, rd_ready2, rd_ready3,
    output rd_valid1, rd_valid2, rd_valid3,
    output rd_data1, rd_data2, rd_data3
  );
endinterface

// File: rtl/mem_shared_rd.sv
// 16x32 memory with one write port and one physical read port shared by
// three windowed 16-bit requesters through a fixed-priority (1 > 2 > 3) arbiter.
module mem_shared_rd #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 16,
  parameter int OFF1    = 0,
  parameter int OFF2    = 8,
  parameter int OFF3    = 16
) (
  input  logic            clk,
  input  logic            rst,
  mem_shared_rd_if.slave  bus
);

  localparam int NREQ  = 3;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [NREQ-1:0]    req_vec;
  logic [ADDR_W-1:0]  addr_in [NREQ];
  logic [NREQ-1:0]    pending_vec;
  logic [ADDR_W-1:0]  addr_q_vec [NREQ];
  logic [NREQ-1:0]    valid_vec;
  logic [SLICE_W-1:0] data_vec [NREQ];

  logic [NREQ-1:0]    gnt_next;
  logic [NREQ-1:0]    gnt_q_reg;
  logic [ADDR_W-1:0]  gnt_addr;
  logic               rd_en;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DATA_W-1:0]  rd_word_reg;

  assign req_vec    = {bus.rd_req3, bus.rd_req2, bus.rd_req1};
  assign addr_in[0] = bus.rd_addr1;
  assign addr_in[1] = bus.rd_addr2;
  assign addr_in[2] = bus.rd_addr3;

  // Only flags already set before this edge compete; fresh acceptances wait.
  always_comb begin
    gnt_next = '0;
    gnt_addr = '0;
    if (pending_vec[0]) begin
      gnt_next = 3'b001;
      gnt_addr = addr_q_vec[0];
    end else if (pending_vec[1]) begin
      gnt_next = 3'b010;
      gnt_addr = addr_q_vec[1];
    end else if (pending_vec[2]) begin
      gnt_next = 3'b100;
      gnt_addr = addr_q_vec[2];
    end
  end

  assign rd_en = (|gnt_next) & ~rst;

  // Plain one-write/one-read array; the read returns the pre-write word.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
    if (rd_en) begin
      rd_word_reg <= mem[gnt_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q_reg <= '0;
    end else begin
      gnt_q_reg <= gnt_next;
    end
  end

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      localparam int OFF = (gi == 0) ? OFF1 : (gi == 1) ? OFF2 : OFF3;

      logic               pending_reg;
      logic [ADDR_W-1:0]  addr_q_reg;
      logic               rd_valid_reg;
      logic [SLICE_W-1:0] rd_data_reg;

      // Accept and grant never coincide: accept needs the flag clear, grant needs it set.
      always_ff @(posedge clk) begin
        if (rst) begin
          pending_reg  <= 1'b0;
          rd_valid_reg <= 1'b0;
          rd_data_reg  <= '0;
        end else begin
          if (req_vec[gi] && !pending_reg) begin
            pending_reg <= 1'b1;
            addr_q_reg  <= addr_in[gi];
          end else if (gnt_next[gi]) begin
            pending_reg <= 1'b0;
          end
          rd_valid_reg <= gnt_q_reg[gi];
          if (gnt_q_reg[gi]) begin
            rd_data_reg <= rd_word_reg[OFF +: SLICE_W];
          end
        end
      end

      assign pending_vec[gi] = pending_reg;
      assign addr_q_vec[gi]  = addr_q_reg;
      assign valid_vec[gi]   = rd_valid_reg;
      assign data_vec[gi]    = rd_data_reg;
    end
  endgenerate

  assign bus.rd_ready1 = ~pending_vec[0];
  assign bus.rd_ready2 = ~pending_vec[1];
  assign bus.rd_ready3 = ~pending_vec[2];
  assign bus.rd_valid1 = valid_vec[0];
  assign bus.rd_valid2 = valid_vec[1];
  assign bus.rd_valid3 = valid_vec[2];
  assign bus.rd_data1  = data_vec[0];
  assign bus.rd_data2  = data_vec[1];
  assign bus.rd_data3  = data_vec[2];

endmodule

// File: tb/tb_mem_shared_rd.sv
// Self-checking bench for mem_shared_rd: directed scenarios plus random
// traffic, all checked against a queue-based transaction model.
module tb_mem_shared_rd;

  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 32;
  localparam int SLICE_W = 16;
  localparam int OFF1    = 0;
  localparam int OFF2    = 8;
  localparam int OFF3    = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_shared_rd_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SLICE_W(SLICE_W)) bus ();

  mem_shared_rd #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SLICE_W(SLICE_W),
    .OFF1(OFF1), .OFF2(OFF2), .OFF3(OFF3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Reference model: memory image, outstanding requests, deliveries in flight.
  typedef struct {
    int          due_edge;
    int          who;
    logic [15:0] data;
  } dlv_t;

  logic [31:0] m_mem [16];
  bit          m_pend [3];
  logic [3:0]  m_addr [3];
  logic [15:0] m_data [3];
  bit          m_valid [3];
  dlv_t        dq [$];
  int          edge_no;

  int n_cmp;
  int n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] window(input logic [31:0] w, input int i);
    case (i)
      0:       window = w[OFF1 +: 16];
      1:       window = w[OFF2 +: 16];
      default: window = w[OFF3 +: 16];
    endcase
  endfunction

  task automatic model_edge(input logic [2:0] req, input logic [3:0] a [3],
                            input logic we, input logic [3:0] wa,
                            input logic [31:0] wd, input logic r);
    int win;
    edge_no++;
    for (int i = 0; i < 3; i++) m_valid[i] = 0;
    if (r) begin
      for (int i = 0; i < 3; i++) begin
        m_pend[i] = 0;
        m_data[i] = '0;
      end
      dq.delete();
    end else begin
      while (dq.size() > 0 && dq[0].due_edge == edge_no) begin
        m_valid[dq[0].who] = 1;
        m_data[dq[0].who]  = dq[0].data;
        void'(dq.pop_front());
      end
      win = -1;
      for (int i = 0; i < 3; i++) begin
        if (win < 0 && m_pend[i]) win = i;
      end
      if (win >= 0) dq.push_back('{edge_no + 1, win, window(m_mem[m_addr[win]], win)});
      for (int i = 0; i < 3; i++) begin
        if (req[i] && !m_pend[i]) begin
          m_pend[i] = 1;
          m_addr[i] = a[i];
        end
      end
      if (win >= 0) m_pend[win] = 0;
    end
    if (we) m_mem[wa] = wd;
  endtask

  task automatic step(input logic [2:0] req, input logic [3:0] a1, input logic [3:0] a2,
                      input logic [3:0] a3, input logic we, input logic [3:0] wa,
                      input logic [31:0] wd, input logic r);
    logic [3:0]  a [3];
    logic [2:0]  got_v;
    logic [2:0]  got_rdy;
    logic [15:0] got_d [3];
    a[0] = a1; a[1] = a2; a[2] = a3;
    bus.rd_req1 = req[0]; bus.rd_req2 = req[1]; bus.rd_req3 = req[2];
    bus.rd_addr1 = a1; bus.rd_addr2 = a2; bus.rd_addr3 = a3;
    bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
    rst = r;
    @(posedge clk);
    model_edge(req, a, we, wa, wd, r);
    #1;
    got_v   = {bus.rd_valid3, bus.rd_valid2, bus.rd_valid1};
    got_rdy = {bus.rd_ready3, bus.rd_ready2, bus.rd_ready1};
    got_d[0] = bus.rd_data1; got_d[1] = bus.rd_data2; got_d[2] = bus.rd_data3;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("valid%0d@%0d", i + 1, edge_no), 32'(got_v[i]), 32'(m_valid[i]));
      chk($sformatf("data%0d@%0d", i + 1, edge_no), 32'(got_d[i]), 32'(m_data[i]));
      chk($sformatf("ready%0d@%0d", i + 1, edge_no), 32'(got_rdy[i]), 32'(!m_pend[i]));
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0);
  endtask

  int cnt;
  logic [3:0] ra1, ra2, ra3, rwa;
  logic [2:0] rreq;

  initial begin
    n_cmp = 0;
    n_err = 0;
    edge_no = 0;
    for (int i = 0; i < 3; i++) begin
      m_pend[i] = 0; m_data[i] = '0; m_addr[i] = '0; m_valid[i] = 0;
    end

    // Fill memory while held in reset: writes must still land.
    for (int i = 0; i < 16; i++)
      step(3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 4'(i), $urandom, 1'b1);
    chk("rst_ready1", 32'(bus.rd_ready1), 32'd1);
    chk("rst_data3", 32'(bus.rd_data3), 32'd0);

    // Single uncontended read.
    step(3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 4'd5, 32'hA1B2C3D4, 1'b0);
    step(3'b001, 4'd5, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0);
    idle(1);
    chk("t1_early_valid1", 32'(bus.rd_valid1), 32'd0);
    idle(1);
    chk("t1_valid1", 32'(bus.rd_valid1), 32'd1);
    chk("t1_data1", 32'(bus.rd_data1), 32'h0000C3D4);
    idle(1);

    // All three at once: consecutive valids in priority order.
    step(3'b111, 4'd5, 4'd5, 4'd5, 1'b0, 4'd0, 32'd0, 1'b0);
    idle(2);
    chk("t2_valid1", 32'(bus.rd_valid1), 32'd1);
    chk("t2_data1", 32'(bus.rd_data1), 32'h0000C3D4);
    idle(1);
    chk("t2_valid2", 32'(bus.rd_valid2), 32'd1);
    chk("t2_data2", 32'(bus.rd_data2), 32'h0000B2C3);
    idle(1);
    chk("t2_valid3", 32'(bus.rd_valid3), 32'd1);
    chk("t2_data3", 32'(bus.rd_data3), 32'h0000A1B2);
    idle(1);

    // Read-before-write at the grant edge.
    step(3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 4'd2, 32'h11112222, 1'b0);
    step(3'b001, 4'd2, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0);
    step(3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 4'd2, 32'h33334444, 1'b0);
    idle(1);
    chk("t3_old_data1", 32'(bus.rd_data1), 32'h00002222);
    step(3'b001, 4'd2, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0);
    idle(2);
    chk("t3_new_data1", 32'(bus.rd_data1), 32'h00004444);
    idle(1);

    // Request while pending is ignored.
    cnt = 0;
    step(3'b001, 4'd5, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0);
    step(3'b001, 4'd7, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0);
    cnt += int'(bus.rd_valid1);
    for (int k = 0; k < 4; k++) begin
      idle(1);
      cnt += int'(bus.rd_valid1);
    end
    chk("t4_pulses1", 32'(cnt), 32'd1);
    chk("t4_data1", 32'(bus.rd_data1), 32'h0000C3D4);

    // Requesters 1 and 2 alternate so one of them is always pending ahead of 3.
    cnt = 0;
    step(3'b101, 4'd1, 4'd0, 4'd9, 1'b0, 4'd0, 32'd0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step(3'b010, 4'd0, 4'd3, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0);
      cnt += int'(bus.rd_valid3);
      step(3'b001, 4'd1, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0);
      cnt += int'(bus.rd_valid3);
    end
    chk("t5_starved3", 32'(cnt), 32'd0);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      idle(1);
      cnt += int'(bus.rd_valid3);
    end
    chk("t5_valid3_after", 32'(cnt), 32'd1);

    // Reset right after requester 1's grant drops everything in flight.
    step(3'b011, 4'd4, 4'd6, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0);
    idle(1);
    step(3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b1);
    chk("t6_ready2", 32'(bus.rd_ready2), 32'd1);
    chk("t6_data1", 32'(bus.rd_data1), 32'd0);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      idle(1);
      cnt += int'(bus.rd_valid1) + int'(bus.rd_valid2) + int'(bus.rd_valid3);
    end
    chk("t6_no_valid", 32'(cnt), 32'd0);

    // Random traffic with occasional resets and concurrent writes.
    for (int k = 0; k < 3000; k++) begin
      rreq = 3'($urandom_range(0, 7));
      ra1 = 4'($urandom); ra2 = 4'($urandom); ra3 = 4'($urandom); rwa = 4'($urandom);
      step(rreq, ra1, ra2, ra3, 1'($urandom_range(0, 1)), rwa, $urandom,
           ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0);
    end
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
